// File: rtl/wramp_mem_pkg.sv
// ----------------------------------------------------------------------------
// wramp_mem_pkg
// Shared constants and types for the WRAMP memory responder:
//   - ADDR_STATUS / ADDR_CYCLES / ADDR_CTRL : memory-mapped register addresses
//   - DONE_MAGIC                            : CTRL value that ends a run
//   - state_t                               : responder FSM states
//   - sat_inc()                             : saturating 32-bit increment
// ----------------------------------------------------------------------------
package wramp_mem_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_STATUS = 20'hffffd;
    localparam logic [ADDR_W-1:0] ADDR_CYCLES = 20'hffffe;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 20'hfffff;

    localparam logic [DATA_W-1:0] DONE_MAGIC  = 32'h0000_dead;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDone  = 2'd1,
        StFault = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wramp_ram.sv
// ----------------------------------------------------------------------------
// wramp_ram
// Word-addressed 32-bit storage: combinational read, synchronous write,
// no reset (contents survive responder reset).
// Ports:
//   clk      - clock, writes commit on posedge
//   i_we     - write enable
//   i_addr   - word address (read and write)
//   i_wdata  - write data
//   o_rdata  - read data for i_addr (pre-write value during a write cycle)
// ----------------------------------------------------------------------------
module wramp_ram #(
    parameter int unsigned WORDS = 65536,
    localparam int unsigned AW   = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/wramp_mem_responder.sv
// ----------------------------------------------------------------------------
// wramp_mem_responder
// Memory responder for a WRAMP CPU: RAM plus STATUS/CYCLES/CTRL registers,
// a RUN/DONE/FAULT run-state FSM and a saturating cycle counter.
// Ports:
//   clk             - clock
//   rst_async       - asynchronous active-low reset
//   mem_address     - 20-bit word address
//   mem_write_en    - write strobe, sampled on posedge clk
//   mem_write_value - write data
//   mem_read_value  - combinational read data for mem_address
//   done            - run finished (magic value written to CTRL)
//   fault           - write to an unmapped address was seen
//   cycle_count     - posedges spent in RUN (saturating)
// ----------------------------------------------------------------------------
module wramp_mem_responder
    import wramp_mem_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 65536
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic [19:0] mem_address,
    input  logic        mem_write_en,
    input  logic [31:0] mem_write_value,
    output logic [31:0] mem_read_value,
    output logic        done,
    output logic        fault,
    output logic [31:0] cycle_count
);

    localparam int unsigned RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_ctrl;
    logic [31:0] r_cycle_count;

    logic        w_sel_ram;
    logic        w_sel_status;
    logic        w_sel_cycles;
    logic        w_sel_ctrl;
    logic        w_mapped;
    logic        w_wr_run;
    logic        w_ram_we;
    logic [31:0] w_ram_rdata;

    // ------------------------------------------------------------------------
    // Address decode: full 20-bit compare, so nothing above RAM aliases into it
    // ------------------------------------------------------------------------
    assign w_sel_ram    = ({12'd0, mem_address} < RAM_WORDS);
    assign w_sel_status = (mem_address == ADDR_STATUS);
    assign w_sel_cycles = (mem_address == ADDR_CYCLES);
    assign w_sel_ctrl   = (mem_address == ADDR_CTRL);
    assign w_mapped     = w_sel_ram | w_sel_status | w_sel_cycles | w_sel_ctrl;

    // Writes only take effect in RUN; DONE and FAULT freeze RAM and CTRL.
    assign w_wr_run = mem_write_en & (r_state == StRun);

    // RAM has no reset of its own, so gate its write enable with reset to
    // drop writes that arrive while reset is held.
    assign w_ram_we = w_wr_run & w_sel_ram & rst_async;

    wramp_ram #(
        .WORDS (RAM_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (mem_address[RAM_AW-1:0]),
        .i_wdata (mem_write_value),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (w_wr_run) begin
            if (w_sel_ctrl && (mem_write_value == DONE_MAGIC)) begin
                w_state_next = StDone;
            end else if (!w_mapped) begin
                w_state_next = StFault;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs (mutually exclusive by construction)
    // ------------------------------------------------------------------------
    always_comb begin
        done  = 1'b0;
        fault = 1'b0;
        unique case (r_state)
            StDone:  done  = 1'b1;
            StFault: fault = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // CTRL register and RUN cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            r_ctrl <= '0;
        end else if (w_wr_run && w_sel_ctrl) begin
            r_ctrl <= mem_write_value;
        end
    end

    // Counts every posedge spent in RUN, including the terminating write.
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            r_cycle_count <= '0;
        end else if (r_state == StRun) begin
            r_cycle_count <= sat_inc(r_cycle_count);
        end
    end

    assign cycle_count = r_cycle_count;

    // ------------------------------------------------------------------------
    // Zero-latency read mux
    // ------------------------------------------------------------------------
    always_comb begin
        mem_read_value = '0;
        if (w_sel_ram) begin
            mem_read_value = w_ram_rdata;
        end else if (w_sel_status) begin
            mem_read_value = {30'd0, fault, done};
        end else if (w_sel_cycles) begin
            mem_read_value = r_cycle_count;
        end else if (w_sel_ctrl) begin
            mem_read_value = r_ctrl;
        end
    end

endmodule

// File: doc/wramp_mem_responder.md
WRAMP_MEM_RESPONDER -- requirements
Module: wramp_mem_responder

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 65536, the number of 32-bit RAM words; it is a power of two and at most 2^19.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on posedge.
REQ-003 SHALL have port rst_async, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port mem_address, input, 20 bits, the word address from the CPU.
REQ-005 SHALL have port mem_write_en, input, 1 bit, the write strobe sampled at posedge clk.
REQ-006 SHALL have port mem_write_value, input, 32 bits, the write data.
REQ-007 SHALL have port mem_read_value, output, 32 bits, the read data.
REQ-008 SHALL have port done, output, 1 bit, asserted when the run completes successfully.
REQ-009 SHALL have port fault, output, 1 bit, asserted after a write to an unmapped address.
REQ-010 SHALL have port cycle_count, output, 32 bits, the number of clocks spent in RUN.

Function
REQ-011 SHALL decode this address map: RAM at 0x00000..RAM_WORDS-1; STATUS at 0xffffd (read-only, bit0=done, bit1=fault, other bits 0); CYCLES at 0xffffe (read-only, returns cycle_count); CTRL at 0xfffff (read/write); all other addresses are unmapped.
REQ-012 SHALL drive mem_read_value combinationally from mem_address with zero latency; unmapped addresses read 0x00000000.
REQ-013 SHALL commit a RAM write at the posedge where mem_write_en=1; a read in that same cycle returns the pre-write value, and the new value is visible from the next cycle.
REQ-014 SHALL ignore writes to STATUS and CYCLES and treat them as mapped, so they do not set fault.
REQ-015 SHALL implement an FSM with states RUN, DONE and FAULT; reset enters RUN.
REQ-016 SHALL leave RUN for DONE on a write of 0x0000dead to CTRL; CTRL captures the value and done asserts in the next cycle.
REQ-017 SHALL, on a write of any other value to CTRL in RUN, capture the value in CTRL and remain in RUN.
REQ-018 SHALL, on a write to an unmapped address in RUN, discard the data and enter FAULT; fault asserts in the next cycle.
REQ-019 SHALL treat DONE and FAULT as terminal until reset: all writes are ignored, RAM and CTRL are frozen, and reads still work.
REQ-020 SHALL increment cycle_count by 1 on each posedge while in RUN, including the cycle of the terminating write; it saturates at 0xffffffff and is frozen in DONE or FAULT.
REQ-021 SHALL ensure done and fault are never asserted together.
REQ-022 SHALL use address bits [19:0] fully with no aliasing: RAM is selected only when mem_address < RAM_WORDS.

Reset
REQ-023 SHALL, when rst_async is low, immediately force state=RUN, done=0, fault=0, cycle_count=0 and CTRL=0, regardless of any in-progress write.
REQ-024 SHALL NOT reset RAM contents; they persist across reset.
REQ-025 SHALL ignore writes while reset is asserted; operation resumes at the first posedge after rst_async deasserts.

Structure
REQ-026 SHALL place the address constants (ADDR_STATUS, ADDR_CYCLES, ADDR_CTRL), the magic value DONE_MAGIC=0x0000dead and the state enum in package wramp_mem_pkg.
REQ-027 SHALL implement the storage array as sub-module wramp_ram (combinational read, synchronous write, no reset); decode, FSM and counters reside in wramp_mem_responder.

Verification
REQ-028 SHALL verify: write 0x12345678 to 0x000ff, then read 0x000ff -> old value in the write cycle, 0x12345678 from the next cycle.
REQ-029 SHALL verify: reset, wait 7 clocks, write 0xdead to 0xfffff -> done=1 next cycle, cycle_count=8 and frozen, STATUS reads 0x1.
REQ-030 SHALL verify: write 0xbeef to 0x40000 with RAM_WORDS=65536 -> fault=1 next cycle, STATUS reads 0x2, a later RAM write is ignored, and 0x40000 reads 0.
REQ-031 SHALL verify: write 0x5 to CTRL -> CTRL reads 0x5 and state stays RUN; write 0xdead afterwards -> done.
REQ-032 SHALL verify: rst_async pulsed low mid-run after DONE -> done=0 and cycle_count=0 immediately (asynchronously), RAM[0xff] retains 0x12345678.
REQ-033 SHALL verify: force cycle_count to 0xfffffffe in RUN, run 3 clocks -> value saturates at 0xffffffff.
